// File: rtl/ser_slot_sched_if.sv
// Requester-side bus for the TDM slot scheduler: per-requester word-ready,
// packed 32-bit words and the one-hot grant returned by the scheduler.
interface ser_slot_sched_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] wdata;
    logic [NREQ-1:0]    gnt;

    modport master (output req, output wdata, input gnt);
    modport slave  (input req, input wdata, output gnt);
endinterface

// File: rtl/ser_slot_sched.sv
// TDM slot scheduler: eight 32-bit slots per 256-bit frame, shared round-robin
// among NREQ requesters and serialized MSB-first. Define SER_SCHED_HDR_EN to reserve slot 0 for a header word.
module ser_slot_sched #(
    parameter int NREQ = 4
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             enable,
    ser_slot_sched_if.slave  bus,
    output logic             sdata,
    output logic             sfs,
    output logic [2:0]       slot_idx,
    output logic [2:0]       slot_owner,
    output logic             slot_valid
);
    logic [7:0]      bit_cnt;
    logic [2:0]      rr;
    logic [30:0]     shreg;
    logic            slot_start;
    logic            arb_ok;
    logic [7:0]      req8;
    logic            gnt_any;
    logic [2:0]      gnt_idx;
    logic [2:0]      cand;
    logic [NREQ-1:0] gnt_c;
    logic [31:0]     words [8];
    logic [31:0]     gnt_word;

    assign slot_start = (bit_cnt[4:0] == 5'd0);
    assign req8       = 8'(bus.req);

`ifdef SER_SCHED_HDR_EN
    logic [7:0]  frame_cnt;
    logic        hdr_slot;
    logic [31:0] hdr_word;

    assign hdr_slot = (bit_cnt[7:5] == 3'd0);
    assign hdr_word = {16'hA5C3, 8'h00, frame_cnt};
    assign arb_ok   = !hdr_slot;
`else
    assign arb_ok   = 1'b1;
`endif

    // Unused word lanes read as zero so the grant index can address all eight.
    for (genvar j = 0; j < 8; j++) begin : g_words
        if (j < NREQ) begin : g_live
            assign words[j] = bus.wdata[32*j +: 32];
        end else begin : g_pad
            assign words[j] = '0;
        end
    end

    assign gnt_word = words[gnt_idx];

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt_c   = '0;
        if (!rst && enable && slot_start && arb_ok) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = 3'((int'(rr) + k) % NREQ);
                if (!gnt_any && req8[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            for (int j = 0; j < NREQ; j++) begin
                gnt_c[j] = gnt_any && (gnt_idx == 3'(j));
            end
        end
    end

    assign bus.gnt = gnt_c;

    always_ff @(posedge sclk) begin
        if (rst) begin
            bit_cnt    <= '0;
            rr         <= '0;
            shreg      <= '0;
            sdata      <= 1'b0;
            sfs        <= 1'b0;
            slot_idx   <= '0;
            slot_owner <= '0;
            slot_valid <= 1'b0;
`ifdef SER_SCHED_HDR_EN
            frame_cnt  <= '0;
`endif
        end else if (enable) begin
            bit_cnt  <= bit_cnt + 8'd1;
            sfs      <= (bit_cnt == 8'd0);
            slot_idx <= bit_cnt[7:5];
            if (slot_start) begin
`ifdef SER_SCHED_HDR_EN
                if (hdr_slot) begin
                    sdata      <= hdr_word[31];
                    shreg      <= hdr_word[30:0];
                    slot_valid <= 1'b0;
                    frame_cnt  <= frame_cnt + 8'd1;
                end else
`endif
                if (gnt_any) begin
                    sdata      <= gnt_word[31];
                    shreg      <= gnt_word[30:0];
                    slot_owner <= gnt_idx;
                    slot_valid <= 1'b1;
                    rr         <= 3'((int'(gnt_idx) + 1) % NREQ);
                end else begin
                    sdata      <= 1'b0;
                    shreg      <= '0;
                    slot_valid <= 1'b0;
                end
            end else begin
                sdata <= shreg[30];
                shreg <= {shreg[29:0], 1'b0};
            end
        end
    end
endmodule
